// File: rtl/exec_unit.sv
// exec_unit: execute stage between the register file and its write port.
// Single-cycle ALU ops write back the cycle after accept. MUL runs an
// iterative shift-add loop (one step per clock, XLEN steps) and writes
// back the cycle after its final step.
//
// Handshake: an op transfers on a rising edge where in_valid && in_ready.
// in_ready depends only on the FSM state, never on in_valid. Decode must
// hold op/operands/rd stable while in_valid is high and in_ready is low.
// busy mirrors the FSM state (1 = MUL) and serves as its debug view.
module exec_unit #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic [RA_W-1:0] in_rd,
    output logic [XLEN-1:0] wb_data,
    output logic [RA_W-1:0] wb_rd,
    output logic            wb_we,
    output logic            busy
);

    localparam int CNT_W = $clog2(XLEN);
    localparam int SH_W  = $clog2(XLEN);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SLL = 3'b101,
        OP_SLT = 3'b110,
        OP_MUL = 3'b111
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_e;

    // FSM state
    state_e r_state;
    state_e w_state_next;

    // Multiply datapath: shifted multiplicand, shifted multiplier,
    // running sum, step counter and the destination held for writeback.
    logic [XLEN-1:0]  r_a;
    logic [XLEN-1:0]  r_b;
    logic [XLEN-1:0]  r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic [RA_W-1:0]  r_rd;

    // Writeback registers
    logic [XLEN-1:0] r_wb_data;
    logic [RA_W-1:0] r_wb_rd;
    logic            r_wb_we;

    // Control decoded from the state
    logic w_in_ready;
    logic w_busy;
    logic w_accept;
    logic w_alu_start;
    logic w_mul_start;
    logic w_mul_done;

    // Datapath combinational values
    logic [XLEN-1:0] w_alu_result;
    logic [XLEN-1:0] w_step_acc;
    logic [SH_W-1:0] w_sh_amt;
    logic            w_lt;
    op_e             w_op;

    assign w_op     = op_e'(in_op);
    assign w_sh_amt = in_b[SH_W-1:0];
    assign w_lt     = ($signed(in_a) < $signed(in_b));

    // Accumulator value after the current multiply step, so the
    // completion edge can write back a sum that includes its own step.
    assign w_step_acc = r_b[0] ? (r_acc + r_a) : r_acc;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake decode
    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_busy       = 1'b0;
        w_accept     = 1'b0;
        w_alu_start  = 1'b0;
        w_mul_start  = 1'b0;
        w_mul_done   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_in_ready = 1'b1;
                w_accept   = in_valid;
                if (w_accept) begin
                    if (w_op == OP_MUL) begin
                        w_mul_start  = 1'b1;
                        w_state_next = ST_MUL;
                    end else begin
                        w_alu_start = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                w_busy = 1'b1;
                if (r_cnt == LAST_STEP) begin
                    w_mul_done   = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Single-cycle ALU result
    always_comb begin
        w_alu_result = '0;
        case (w_op)
            OP_ADD:  w_alu_result = in_a + in_b;
            OP_SUB:  w_alu_result = in_a - in_b;
            OP_AND:  w_alu_result = in_a & in_b;
            OP_OR:   w_alu_result = in_a | in_b;
            OP_XOR:  w_alu_result = in_a ^ in_b;
            OP_SLL:  w_alu_result = in_a << w_sh_amt;
            OP_SLT:  w_alu_result = {{(XLEN-1){1'b0}}, w_lt};
            default: w_alu_result = '0;
        endcase
    end

    // Multiply operand latch and shift-add iteration
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
            r_cnt <= '0;
            r_rd  <= '0;
        end else if (w_mul_start) begin
            r_a   <= in_a;
            r_b   <= in_b;
            r_acc <= '0;
            r_cnt <= '0;
            r_rd  <= in_rd;
        end else if (w_busy) begin
            r_acc <= w_step_acc;
            r_a   <= r_a << 1;
            r_b   <= r_b >> 1;
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Writeback: one-cycle write pulse per completed op; x0 is never written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_data <= '0;
            r_wb_rd   <= '0;
            r_wb_we   <= 1'b0;
        end else if (w_alu_start) begin
            r_wb_data <= w_alu_result;
            r_wb_rd   <= in_rd;
            r_wb_we   <= (in_rd != '0);
        end else if (w_mul_done) begin
            r_wb_data <= w_step_acc;
            r_wb_rd   <= r_rd;
            r_wb_we   <= (r_rd != '0);
        end else begin
            r_wb_we   <= 1'b0;
        end
    end

    assign in_ready = w_in_ready;
    assign busy     = w_busy;
    assign wb_data  = r_wb_data;
    assign wb_rd    = r_wb_rd;
    assign wb_we    = r_wb_we;

endmodule

// File: tb/tb_exec_unit.sv
// tb_exec_unit: scoreboard bench for exec_unit. A driver issues ops and
// pushes the expected writeback (value, rd, cycle) computed by a plain
// arithmetic reference model; a negedge monitor pops and compares.
module tb_exec_unit;

    localparam int XLEN = 32;
    localparam int RA_W = 5;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      in_op;
    logic [XLEN-1:0] in_a;
    logic [XLEN-1:0] in_b;
    logic [RA_W-1:0] in_rd;
    logic [XLEN-1:0] wb_data;
    logic [RA_W-1:0] wb_rd;
    logic            wb_we;
    logic            busy;

    exec_unit #(.XLEN(XLEN), .RA_W(RA_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_op    (in_op),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_rd    (in_rd),
        .wb_data  (wb_data),
        .wb_rd    (wb_rd),
        .wb_we    (wb_we),
        .busy     (busy)
    );

    // ---------------- clock / reset block ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [XLEN-1:0] data;
        logic [RA_W-1:0] rd;
        int              cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   busy_until = 0;  // first cycle index at which the unit is free again

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: the architectural result of each op
    function automatic logic [XLEN-1:0] ref_model(input logic [2:0] op,
                                                   input logic [XLEN-1:0] a,
                                                   input logic [XLEN-1:0] b);
        logic [63:0] p;
        logic [4:0]  sh;
        sh = b[4:0];
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return a << sh;
            3'd6: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: begin
                p = {32'd0, a} * {32'd0, b};
                return p[31:0];
            end
        endcase
    endfunction

    // Monitor: every write pulse must match the head of the queue, at the
    // expected cycle; a due entry with no pulse is reported as missing.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (wb_we) begin
                if (exp_q.size() == 0) begin
                    chk("wb_unexpected_pulse", wb_we, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    chk("wb_data", wb_data, e.data);
                    chk("wb_rd", wb_rd, e.rd);
                    chk("wb_cycle", cyc, e.cyc);
                end
            end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                chk("wb_missing_pulse", wb_we, 1'b1);
                void'(exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input logic [2:0] op, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [RA_W-1:0] rd);
        exp_t e;
        int   n;
        bit   model_ready;
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_rd    = rd;
        for (int w = 0; w < 100; w++) begin
            model_ready = (cyc >= busy_until);
            chk("in_ready", in_ready, model_ready);
            chk("busy", busy, !model_ready);
            if (model_ready) break;
            @(negedge clk);
        end
        n = cyc + 1;  // cycle index right after the accepting edge
        if (op == 3'd7) busy_until = n + 32;
        if (rd != '0) begin
            e.data = ref_model(op, a, b);
            e.rd   = rd;
            e.cyc  = (op == 3'd7) ? n + 32 : n;
            exp_q.push_back(e);
        end
        @(posedge clk);
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_op    = 3'($urandom_range(0, 7));
            in_a     = $urandom;
            in_b     = $urandom;
            in_rd    = 5'($urandom_range(0, 31));
        end
    endtask

    // Asynchronous reset taken between edges; outputs must clear at once.
    task automatic reset_now();
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        busy_until = 0;
        #1;
        chk("rst_wb_we", wb_we, 1'b0);
        chk("rst_wb_data", wb_data, '0);
        chk("rst_wb_rd", wb_rd, '0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("post_rst_in_ready", in_ready, 1'b1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [XLEN-1:0] corner [6];
        logic [2:0]      r_op;
        logic [XLEN-1:0] r_a;
        logic [XLEN-1:0] r_b;
        logic [RA_W-1:0] r_rd;

        corner[0] = 32'h0000_0000;
        corner[1] = 32'hFFFF_FFFF;
        corner[2] = 32'h8000_0000;
        corner[3] = 32'h7FFF_FFFF;
        corner[4] = 32'h0000_0001;
        corner[5] = 32'h0000_001F;

        rst_n = 1'b0;
        in_valid = 1'b0;
        in_op = '0;
        in_a = '0;
        in_b = '0;
        in_rd = '0;
        #3;
        chk("init_wb_we", wb_we, 1'b0);
        chk("init_wb_data", wb_data, '0);
        chk("init_in_ready", in_ready, 1'b1);
        chk("init_busy", busy, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // back-to-back ALU
        issue(3'd0, 32'd5, 32'd7, 5'd3);
        issue(3'd1, 32'd2, 32'd3, 5'd4);
        issue(3'd6, 32'hFFFF_FFFF, 32'd1, 5'd5);
        // shift and logic
        issue(3'd5, 32'd1, 32'h0000_0024, 5'd6);
        issue(3'd4, 32'hF0F0_F0F0, 32'hFFFF_0000, 5'd8);
        issue(3'd2, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd9);
        issue(3'd3, 32'hF000_0000, 32'h0000_000F, 5'd10);
        issue(3'd6, 32'd1, 32'hFFFF_FFFF, 5'd11);
        idle(2);

        // MUL followed by an ADD held through the stall
        issue(3'd7, 32'h0001_0003, 32'h0000_0005, 5'd7);
        issue(3'd0, 32'd10, 32'd20, 5'd12);
        issue(3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd13);
        idle(1);

        // rd = 0 suppresses the write
        issue(3'd0, 32'd1, 32'd1, 5'd0);
        issue(3'd7, 32'd3, 32'd4, 5'd0);
        issue(3'd0, 32'd2, 32'd2, 5'd14);
        idle(3);

        // reset while an ALU result is on the write port
        issue(3'd0, 32'd9, 32'd9, 5'd15);
        reset_now();

        // reset aborts a multiply in flight
        issue(3'd7, 32'd1234, 32'd5678, 5'd16);
        repeat (10) @(posedge clk);
        reset_now();
        idle(40);

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            r_op = ($urandom_range(0, 9) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
            r_a  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
            r_b  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
            r_rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            issue(r_op, r_a, r_b, r_rd);
            if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
        end
        idle(40);

        chk("queue_drained", exp_q.size(), 0);

        // ---------------- final report ----------------
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
